filter_sequencer: RTL and testbench
===================================

// Module: filter_sequencer
// PURPOSE
//  Frame-level controller for the Filter-GPU convolution datapath. Latches the operator's filter
//  select (kernel1/kernel2/kernel3/identity) and walks the source image pixel by pixel.
//  For each pixel: issues the 3x3 neighbourhood reads with edge clamping, hands the taps to the MAC
//  with a start/done handshake, then writes the result to the frame buffer scanned by the VGA side.
// PARAMETERS
//  IMG_W   100  image width in pixels
//  IMG_H   100  image height in pixels
//  ADDR_W  14   address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-low reset
//  kernel1    in   1       level select, priority 1 (highest)
//  kernel2    in   1       level select, priority 2
//  kernel3    in   1       level select, priority 3
//  identity   in   1       level select, priority 4 (lowest)
//  rd_en      out  1       source read strobe; data valid on rd_data one cycle later
//  rd_addr    out  ADDR_W  source address
//  tap_valid  out  1       rd_data for tap tap_idx is valid this cycle (MAC shifts it in)
//  tap_idx    out  4       tap index 0..8, row-major from (-1,-1)
//  kernel_sel out  2       0 = identity, 1..3 = kernelN; held constant for a whole frame
//  mac_start  out  1       one-cycle pulse: all 9 taps delivered
//  mac_done   in   1       one-cycle pulse from MAC: result valid on its output
//  wr_en      out  1       frame-buffer write strobe (one cycle)
//  wr_addr    out  ADDR_W  destination address = y*IMG_W+x
//  busy       out  1       high from frame start through the last write
//  frame_done out  1       one-cycle pulse, the cycle after the last write
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, x=y=0, pending=0, select-edge registers cleared. Reset mid-frame
//   aborts immediately and never issues a partial write afterwards.
//  Select decode: the rising edge of any select input (registered previous value) is a request.
//   Priority when simultaneous: kernel1 > kernel2 > kernel3 > identity.
//   In IDLE, a request latches kernel_sel and starts a frame next cycle.
//   While busy, a request sets pending and overwrites pending_sel. After DONE, pending=1 starts a new
//   frame with pending_sel; no IDLE cycle is spent.
//  FSM: IDLE -> FETCH -> DRAIN -> MAC -> WAIT -> WRITE -> (NEXT | DONE) -> IDLE/FETCH.
//   FETCH: 9 consecutive cycles of rd_en, tap k=0..8. In identity mode there is 1 cycle, centre tap
//    only, tap_idx=4.
//   DRAIN: 1 cycle; tap_valid follows rd_en by exactly one cycle, with tap_idx delayed to match.
//   MAC: mac_start pulse for 1 cycle; skipped in identity mode.
//   WAIT: hold until mac_done, with no timeout. mac_done arriving outside WAIT is ignored. Skipped in
//    identity mode.
//   WRITE: wr_en=1 for 1 cycle at wr_addr of the current (x,y).
//   NEXT: x++; at x=IMG_W-1, wrap x=0 and y++. At the last pixel (IMG_W-1,IMG_H-1), go to DONE.
//   DONE: frame_done=1 and busy=0 for 1 cycle.
//  Per-pixel latency: kernel mode 13 cycles + MAC wait; identity mode 4 cycles (FETCH, DRAIN, WRITE,
//   NEXT/DONE).
//  Tap address: the neighbour at (x+dx, y+dy), dx,dy in {-1,0,1}, with each coordinate clamped to
//   [0, IMG_W-1] or [0, IMG_H-1] (edge replicate). addr = cy*IMG_W+cx, computed unsigned at ADDR_W
//   bits with no overflow permitted.
//  kernel_sel never changes while busy=1.
// STRUCTURE
//  filter_pkg: typedef enum seq_state_t {IDLE, FETCH, DRAIN, MAC, WAIT, WRITE, NEXT, DONE};
//   typedef enum logic[1:0] kernel_sel_t {SEL_ID, SEL_K1, SEL_K2, SEL_K3};
//   localparam arrays TAP_DX[9] / TAP_DY[9]; localparam CENTRE_TAP=4.
//  Sub-module filter_addr_gen: combinational clamp plus multiply-add, (x,y,tap)->rd_addr.
//   Instantiated once.
// TESTING (IMG_W=4, IMG_H=3, MAC model returns mac_done 3 cycles after mac_start)
//  1 Reset held low, then released with no selects -> all outputs 0, busy=0 indefinitely.
//  2 kernel1 rises -> kernel_sel=1; pixel (0,0) rd_addr sequence 0,0,1,0,0,1,4,4,5.
//    Pixel (1,1) sequence 0,1,2,4,5,6,8,9,10.
//  3 identity rises -> 12 writes, wr_addr 0..11 in order, each 4 cycles apart.
//    No mac_start; frame_done 1 cycle after wr_addr=11.
//  4 kernel2 and kernel3 rise in the same cycle -> kernel_sel=2.
//    kernel3 rises mid-frame -> frame finishes with sel=2, then the next frame starts with sel=3 and
//    no IDLE cycle.
//  5 Hold off mac_done for 50 cycles -> FSM stays in WAIT, wr_en=0, no extra mac_start.
//    A stray mac_done in FETCH is ignored.
//  6 Drive reset low during pixel 5's WAIT -> outputs 0 asynchronously. After release, no write
//    occurs until a new select edge arrives.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and tap geometry for the Filter-GPU frame sequencer.
package filter_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, MAC, WAIT, WRITE, NEXT, DONE} seq_state_t;
   typedef enum logic [1:0] {SEL_ID, SEL_K1, SEL_K2, SEL_K3} kernel_sel_t;

   // Row-major 3x3 neighbourhood offsets, tap 0 = (-1,-1)
   localparam int TAP_DX [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
   localparam int TAP_DY [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
   localparam int CENTRE_TAP = 4;
   localparam int LAST_TAP   = 8;

endpackage

// File: rtl/filter_addr_gen.sv
// Source address for one neighbourhood tap of pixel (x,y), edge-replicated at the borders.
module filter_addr_gen
   import filter_pkg::*;
#(
   parameter int IMG_W  = 100,
   parameter int IMG_H  = 100,
   parameter int ADDR_W = 14
) (
   input  logic [ADDR_W-1:0] x,
   input  logic [ADDR_W-1:0] y,
   input  logic [3:0]        tap,
   output logic [ADDR_W-1:0] addr
);

   logic [3:0] ti;
   int         cx;
   int         cy;

   always_comb begin
      ti = (tap > 4'(LAST_TAP)) ? 4'(CENTRE_TAP) : tap;
      cx = int'(x) + TAP_DX[ti];
      cy = int'(y) + TAP_DY[ti];
      if (cx < 0)              cx = 0;
      else if (cx > IMG_W - 1) cx = IMG_W - 1;
      if (cy < 0)              cy = 0;
      else if (cy > IMG_H - 1) cy = IMG_H - 1;
      addr = ADDR_W'(cy * IMG_W + cx);
   end

endmodule

// File: rtl/filter_sequencer.sv
// Frame-level controller: per pixel fetches the 3x3 taps, runs the MAC handshake, writes the result.
module filter_sequencer
   import filter_pkg::*;
#(
   parameter int IMG_W  = 100,
   parameter int IMG_H  = 100,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              kernel1,
   input  logic              kernel2,
   input  logic              kernel3,
   input  logic              identity,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              tap_valid,
   output logic [3:0]        tap_idx,
   output logic [1:0]        kernel_sel,
   output logic              mac_start,
   input  logic              mac_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              frame_done
);

   seq_state_t        state, next_state;
   kernel_sel_t       sel_q, pending_sel, req_sel, start_sel;
   logic [3:0]        sel_prev, rise;
   logic              req, pending, start_frame, last_px;
   logic [3:0]        tap;
   logic [ADDR_W-1:0] x, y, gen_addr;

   filter_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr_gen (
      .x    (x),
      .y    (y),
      .tap  (tap),
      .addr (gen_addr)
   );

   assign rise    = {kernel1, kernel2, kernel3, identity} & ~sel_prev;
   assign req     = |rise;
   assign req_sel = rise[3] ? SEL_K1 : rise[2] ? SEL_K2 : rise[1] ? SEL_K3 : SEL_ID;
   assign last_px = (x == ADDR_W'(IMG_W - 1)) && (y == ADDR_W'(IMG_H - 1));

   always_comb begin
      next_state  = state;
      start_frame = 1'b0;
      start_sel   = req_sel;
      rd_en       = 1'b0;
      mac_start   = 1'b0;
      wr_en       = 1'b0;
      frame_done  = 1'b0;
      case (state)
         IDLE:  if (req) begin
                   start_frame = 1'b1;
                   next_state  = FETCH;
                end
         FETCH: begin
                   rd_en = 1'b1;
                   if (tap == 4'(LAST_TAP) || sel_q == SEL_ID) next_state = DRAIN;
                end
         DRAIN: next_state = (sel_q == SEL_ID) ? WRITE : MAC;
         MAC:   begin
                   mac_start  = 1'b1;
                   next_state = WAIT;
                end
         WAIT:  if (mac_done) next_state = WRITE;
         WRITE: begin
                   wr_en      = 1'b1;
                   next_state = last_px ? DONE : NEXT;
                end
         NEXT:  next_state = FETCH;
         DONE:  begin
                   frame_done = 1'b1;
                   // A request arriving in DONE itself is newer than anything pending
                   if (req || pending) begin
                      start_frame = 1'b1;
                      start_sel   = req ? req_sel : pending_sel;
                      next_state  = FETCH;
                   end else begin
                      next_state = IDLE;
                   end
                end
         default: next_state = IDLE;
      endcase
   end

   assign busy       = (state != IDLE) && (state != DONE);
   assign kernel_sel = sel_q;
   assign rd_addr    = rd_en ? gen_addr : '0;
   assign wr_addr    = wr_en ? ADDR_W'(int'(y) * IMG_W + int'(x)) : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         sel_prev    <= '0;
         sel_q       <= SEL_ID;
         pending     <= 1'b0;
         pending_sel <= SEL_ID;
         tap         <= '0;
         x           <= '0;
         y           <= '0;
         tap_valid   <= 1'b0;
         tap_idx     <= '0;
      end else begin
         state     <= next_state;
         sel_prev  <= {kernel1, kernel2, kernel3, identity};
         tap_valid <= rd_en;
         tap_idx   <= rd_en ? tap : '0;

         if (start_frame) begin
            pending <= 1'b0;
         end else if (req) begin
            pending     <= 1'b1;
            pending_sel <= req_sel;
         end

         if (start_frame) begin
            sel_q <= start_sel;
            tap   <= (start_sel == SEL_ID) ? 4'(CENTRE_TAP) : '0;
            x     <= '0;
            y     <= '0;
         end else if (state == FETCH && next_state == FETCH) begin
            tap <= tap + 4'd1;
         end else if (state == NEXT) begin
            tap <= (sel_q == SEL_ID) ? 4'(CENTRE_TAP) : '0;
            if (x == ADDR_W'(IMG_W - 1)) begin
               x <= '0;
               y <= y + ADDR_W'(1);
            end else begin
               x <= x + ADDR_W'(1);
            end
         end else if (state == DONE) begin
            x <= '0;
            y <= '0;
         end
      end
   end

endmodule

// File: tb/tb_filter_sequencer.sv
// Self-checking bench for filter_sequencer on a 4x3 image with a fixed-latency MAC model.
module tb_filter_sequencer;

   localparam int W = 4;
   localparam int H = 3;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          kernel1 = 1'b0, kernel2 = 1'b0, kernel3 = 1'b0, identity = 1'b0;
   logic          rd_en, tap_valid, mac_start, wr_en, busy, frame_done;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [3:0]    tap_idx;
   logic [1:0]    kernel_sel;
   logic          mac_done, done_m = 1'b0, stray = 1'b0;

   assign mac_done = done_m | stray;

   filter_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3),
      .identity(identity), .rd_en(rd_en), .rd_addr(rd_addr), .tap_valid(tap_valid),
      .tap_idx(tap_idx), .kernel_sel(kernel_sel), .mac_start(mac_start), .mac_done(mac_done),
      .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input bit ok, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- expectation model ----------------
   typedef struct {int sel; bit chained;} frame_t;
   frame_t frame_q[$];
   int     rd_q[$], tap_q[$], wr_q[$];
   int     rd_log[$], wr_log[$];

   function automatic int nb_addr(int px, int py, int k);
      int cx = px + (k % 3) - 1;
      int cy = py + (k / 3) - 1;
      cx = (cx < 0) ? 0 : (cx > W - 1) ? W - 1 : cx;
      cy = (cy < 0) ? 0 : (cy > H - 1) ? H - 1 : cy;
      return cy * W + cx;
   endfunction

   task automatic expect_frame(input int sel, input bit chained);
      frame_t f;
      f.sel = sel;
      f.chained = chained;
      frame_q.push_back(f);
      for (int py = 0; py < H; py++)
         for (int px = 0; px < W; px++) begin
            for (int k = 0; k < 9; k++)
               if (sel != 0 || k == 4) begin
                  rd_q.push_back(nb_addr(px, py, k));
                  tap_q.push_back(k);
               end
            wr_q.push_back(py * W + px);
         end
   endtask

   // ---------------- MAC model: done pulse mac_delay cycles after start ----------------
   int mac_delay = 3;
   int mac_cnt = 0;
   always @(negedge clk) begin
      done_m = 1'b0;
      if (!reset) mac_cnt = 0;
      else if (mac_start) mac_cnt = mac_delay;
      else if (mac_cnt > 0) begin
         mac_cnt--;
         if (mac_cnt == 0) done_m = 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   int     cyc = 0, done_cyc = -100, last_wr = 0, mac_cyc = 0, mac_dly = 0;
   int     px_wr = 0, mac_n = 0, wr_total = 0, mac_total = 0, pend_tap = 0;
   bit     in_frame = 0, prev_rd = 0;
   frame_t cur;

   function automatic bit outs_zero();
      return !rd_en && rd_addr == 0 && !tap_valid && tap_idx == 0 && !mac_start &&
             !wr_en && wr_addr == 0 && !busy && !frame_done;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         chk("reset_outputs", outs_zero() && kernel_sel == 0, int'(busy), 0);
         in_frame = 0;
         prev_rd  = 0;
      end else begin
         chk("tap_valid", tap_valid == prev_rd, int'(tap_valid), int'(prev_rd));
         if (prev_rd) chk("tap_idx", tap_idx == pend_tap, int'(tap_idx), pend_tap);
         prev_rd = rd_en;
         if (rd_en) begin
            if (!in_frame) begin
               if (frame_q.size() == 0) chk("unexpected_frame", 0, 1, 0);
               else begin
                  cur = frame_q.pop_front();
                  if (cur.chained) chk("no_idle_gap", cyc == done_cyc + 1, cyc - done_cyc, 1);
               end
               in_frame = 1;
               px_wr    = 0;
               mac_n    = 0;
            end
            if (rd_q.size() == 0) chk("rd_extra", 0, int'(rd_addr), -1);
            else begin
               chk("rd_addr", rd_addr == rd_q[0], int'(rd_addr), rd_q[0]);
               void'(rd_q.pop_front());
               pend_tap = tap_q.pop_front();
            end
            rd_log.push_back(int'(rd_addr));
         end
         if (in_frame && !frame_done) begin
            chk("busy", busy == 1'b1, int'(busy), 1);
            chk("kernel_sel", kernel_sel == cur.sel, int'(kernel_sel), cur.sel);
         end
         if (mac_start) begin
            mac_total++;
            chk("mac_start", in_frame && cur.sel != 0 && mac_n == 0, mac_n, 0);
            mac_n++;
            mac_cyc = cyc;
            mac_dly = mac_delay;
         end
         if (wr_en && in_frame) begin
            wr_total++;
            wr_log.push_back(int'(wr_addr));
            if (wr_q.size() == 0) chk("wr_extra", 0, int'(wr_addr), -1);
            else begin
               chk("wr_addr", wr_addr == wr_q[0], int'(wr_addr), wr_q[0]);
               void'(wr_q.pop_front());
            end
            if (cur.sel != 0) begin
               chk("mac_per_pixel", mac_n == 1, mac_n, 1);
               chk("mac_to_write", cyc - mac_cyc == mac_dly + 1, cyc - mac_cyc, mac_dly + 1);
               if (px_wr > 0) chk("kernel_pixel_period", cyc - last_wr == 13 + mac_dly,
                                  cyc - last_wr, 13 + mac_dly);
            end else if (px_wr > 0) begin
               chk("identity_pixel_period", cyc - last_wr == 4, cyc - last_wr, 4);
            end
            last_wr = cyc;
            mac_n   = 0;
            px_wr++;
         end
         if (frame_done) begin
            chk("frame_done_timing", in_frame && px_wr == W * H && cyc == last_wr + 1,
                cyc - last_wr, 1);
            chk("busy_done", busy == 1'b0, int'(busy), 0);
            in_frame = 0;
            done_cyc = cyc;
         end
         if (!in_frame && !frame_done) chk("idle_outputs", outs_zero(), int'(busy), 0);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse(input logic [3:0] s);
      tick(1);
      {kernel1, kernel2, kernel3, identity} = s;
      tick(1);
      {kernel1, kernel2, kernel3, identity} = 4'b0000;
   endtask

   task automatic wait_idle(input string name);
      int i = 0;
      while ((frame_q.size() != 0 || in_frame) && i < 2000) begin
         @(posedge clk);
         i++;
      end
      chk(name, frame_q.size() == 0 && !in_frame, frame_q.size() + int'(in_frame), 0);
      tick(1);
   endtask

   int exp00[9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
   int exp11[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   int base_wr, base_mac, i;

   initial begin
      // 1: reset, then idle with no selects
      tick(5);
      reset = 1'b1;
      tick(20);
      chk("idle_busy", busy == 1'b0, int'(busy), 0);
      chk("idle_sel", kernel_sel == 2'd0, int'(kernel_sel), 0);

      // 2: kernel1 frame, clamped neighbourhood addresses
      rd_log.delete();
      expect_frame(1, 0);
      pulse(4'b1000);
      tick(3);
      chk("k1_sel", kernel_sel == 2'd1, int'(kernel_sel), 1);
      wait_idle("k1_frame_complete");
      chk("k1_rd_count", rd_log.size() == 9 * W * H, rd_log.size(), 9 * W * H);
      for (int k = 0; k < 9; k++) begin
         chk("px00_addr", rd_log[k] == exp00[k], rd_log[k], exp00[k]);
         chk("px11_addr", rd_log[45 + k] == exp11[k], rd_log[45 + k], exp11[k]);
      end

      // 3: identity frame, writes 0..11 with no MAC
      wr_log.delete();
      base_mac = mac_total;
      expect_frame(0, 0);
      pulse(4'b0001);
      wait_idle("id_frame_complete");
      chk("id_wr_count", wr_log.size() == W * H, wr_log.size(), W * H);
      for (int k = 0; k < W * H; k++) chk("id_wr_order", wr_log[k] == k, wr_log[k], k);
      chk("id_no_mac", mac_total == base_mac, mac_total - base_mac, 0);

      // 4: simultaneous kernel2+kernel3, then kernel3 mid-frame chains a second frame
      expect_frame(2, 0);
      pulse(4'b0110);
      base_wr = wr_total;
      i = 0;
      while (wr_total < base_wr + 3 && i < 500) begin tick(1); i++; end
      chk("k23_progress", wr_total >= base_wr + 3, wr_total - base_wr, 3);
      chk("k23_sel", kernel_sel == 2'd2, int'(kernel_sel), 2);
      expect_frame(3, 1);
      pulse(4'b0010);
      tick(2);
      chk("k23_sel_held", kernel_sel == 2'd2, int'(kernel_sel), 2);
      wait_idle("chained_frames_complete");
      chk("k3_sel", kernel_sel == 2'd3, int'(kernel_sel), 3);

      // 5: long MAC hold-off on the first pixel, stray mac_done during FETCH
      mac_delay = 50;
      base_mac = mac_total;
      base_wr = wr_total;
      expect_frame(1, 0);
      pulse(4'b1000);
      i = 0;
      while (mac_total == base_mac && i < 100) begin tick(1); i++; end
      chk("hold_mac_seen", mac_total == base_mac + 1, mac_total - base_mac, 1);
      tick(45);
      chk("hold_no_write", wr_total == base_wr, wr_total - base_wr, 0);
      chk("hold_no_restart", mac_total == base_mac + 1, mac_total - base_mac, 1);
      i = 0;
      while (wr_total == base_wr && i < 100) begin tick(1); i++; end
      mac_delay = 3;
      i = 0;
      while (!rd_en && i < 100) begin tick(1); i++; end
      stray = 1'b1;
      tick(1);
      stray = 1'b0;
      wait_idle("hold_frame_complete");

      // 6: reset during pixel 5's WAIT aborts the frame
      expect_frame(1, 0);
      base_wr = wr_total;
      pulse(4'b1000);
      i = 0;
      while (wr_total < base_wr + 5 && i < 500) begin tick(1); i++; end
      base_mac = mac_total;
      i = 0;
      while (mac_total == base_mac && i < 100) begin tick(1); i++; end
      chk("abort_in_wait", mac_total == base_mac + 1 && wr_total == base_wr + 5,
          wr_total - base_wr, 5);
      reset = 1'b0;
      frame_q.delete();
      rd_q.delete();
      tap_q.delete();
      wr_q.delete();
      #1;
      chk("async_reset_outputs", outs_zero() && kernel_sel == 0, int'(busy), 0);
      tick(3);
      reset = 1'b1;
      base_wr = wr_total;
      tick(40);
      chk("no_write_after_abort", wr_total == base_wr, wr_total - base_wr, 0);
      chk("idle_after_abort", busy == 1'b0, int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
